// File: rtl/hdlc_tx_frame_ctrl.sv
// HDLC transmit frame sequencer: picks idle, flag, payload, FCS or abort byte
// for each serializer request and drives the frame status flags.
module hdlc_tx_frame_ctrl #(
  parameter int          MAX_BYTES  = 126,
  parameter logic [7:0]  IDLE_BYTE  = 8'hFF,
  parameter logic [7:0]  FLAG_BYTE  = 8'h7E,
  parameter logic [7:0]  ABORT_BYTE = 8'hFE
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Tx_Enable,
  input  logic        Tx_AbortFrame,
  input  logic [7:0]  Tx_FrameSize,
  output logic [6:0]  Buf_RdAddr,
  input  logic [7:0]  Buf_RdData,
  output logic        Crc_Init,
  output logic        Crc_Update,
  output logic [7:0]  Crc_Byte,
  input  logic [15:0] Crc_Value,
  input  logic        Ser_Req,
  output logic        Ser_Load,
  output logic [7:0]  Ser_Byte,
  output logic        Ser_ZeroIns,
  output logic        Tx_ValidFrame,
  output logic        Tx_Done,
  output logic        Tx_AbortedTrans
);

  // state  | meaning
  // IDLE   | no frame, idle bytes on request
  // START  | opening flag pending
  // DATA   | payload bytes from buffer, CRC accumulating
  // FCS_LO | low CRC byte pending
  // FCS_HI | latched high CRC byte pending
  // END    | closing flag pending
  // ABORT  | abort pattern pending
  typedef enum logic [2:0] {
    IDLE, START, DATA, FCS_LO, FCS_HI, END, ABORT
  } state_t;

  state_t     state;
  logic [7:0] frame_size;
  logic [7:0] crc_hi;

  logic size_ok;
  logic abort_ok;
  logic last_byte;

  assign size_ok   = (Tx_FrameSize != 8'd0) && (Tx_FrameSize <= 8'(MAX_BYTES));
  assign abort_ok  = (state == START) || (state == DATA) || (state == FCS_LO) ||
                     (state == FCS_HI) || (state == END);
  assign last_byte = ({1'b0, Buf_RdAddr} == (frame_size - 8'd1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state           <= IDLE;
      frame_size      <= 8'd0;
      crc_hi          <= 8'd0;
      Buf_RdAddr      <= 7'd0;
      Crc_Init        <= 1'b0;
      Crc_Update      <= 1'b0;
      Crc_Byte        <= 8'd0;
      Ser_Load        <= 1'b0;
      Ser_Byte        <= IDLE_BYTE;
      Ser_ZeroIns     <= 1'b0;
      Tx_ValidFrame   <= 1'b0;
      Tx_Done         <= 1'b1;
      Tx_AbortedTrans <= 1'b0;
    end else begin
      Ser_Load   <= 1'b0;
      Crc_Init   <= 1'b0;
      Crc_Update <= 1'b0;

      if ((state == IDLE) && Tx_Enable && size_ok) begin
        state           <= START;
        frame_size      <= Tx_FrameSize;
        Crc_Init        <= 1'b1;
        Buf_RdAddr      <= 7'd0;
        Tx_Done         <= 1'b0;
        Tx_AbortedTrans <= 1'b0;
        Tx_ValidFrame   <= 1'b1;
        // a request coinciding with the start still gets an idle byte
        if (Ser_Req) begin
          Ser_Load    <= 1'b1;
          Ser_Byte    <= IDLE_BYTE;
          Ser_ZeroIns <= 1'b0;
        end
      end else if (abort_ok && Tx_AbortFrame) begin
        Tx_AbortedTrans <= 1'b1;
        Tx_Done         <= 1'b1;
        if (Ser_Req) begin
          Ser_Load      <= 1'b1;
          Ser_Byte      <= ABORT_BYTE;
          Ser_ZeroIns   <= 1'b0;
          Tx_ValidFrame <= 1'b0;
          state         <= IDLE;
        end else begin
          state <= ABORT;
        end
      end else if (Ser_Req) begin
        Ser_Load <= 1'b1;
        case (state)
          START: begin
            Ser_Byte    <= FLAG_BYTE;
            Ser_ZeroIns <= 1'b0;
            state       <= DATA;
          end
          DATA: begin
            Ser_Byte    <= Buf_RdData;
            Ser_ZeroIns <= 1'b1;
            Crc_Update  <= 1'b1;
            Crc_Byte    <= Buf_RdData;
            // address parks on the last index so it never passes MAX_BYTES-1
            if (last_byte) begin
              Tx_Done <= 1'b1;
              state   <= FCS_LO;
            end else begin
              Buf_RdAddr <= Buf_RdAddr + 7'd1;
            end
          end
          FCS_LO: begin
            Ser_Byte    <= Crc_Value[7:0];
            Ser_ZeroIns <= 1'b1;
            crc_hi      <= Crc_Value[15:8];
            state       <= FCS_HI;
          end
          FCS_HI: begin
            Ser_Byte    <= crc_hi;
            Ser_ZeroIns <= 1'b1;
            state       <= END;
          end
          END: begin
            Ser_Byte      <= FLAG_BYTE;
            Ser_ZeroIns   <= 1'b0;
            Tx_ValidFrame <= 1'b0;
            state         <= IDLE;
          end
          ABORT: begin
            Ser_Byte      <= ABORT_BYTE;
            Ser_ZeroIns   <= 1'b0;
            Tx_ValidFrame <= 1'b0;
            state         <= IDLE;
          end
          default: begin
            Ser_Byte    <= IDLE_BYTE;
            Ser_ZeroIns <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// Directed bench for hdlc_tx_frame_ctrl: buffer and CRC value are modelled
// by the bench, every load is compared against hand-computed bytes.
module tb_hdlc_tx_frame_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Tx_Enable;
  logic        Tx_AbortFrame;
  logic [7:0]  Tx_FrameSize;
  logic [6:0]  Buf_RdAddr;
  logic [7:0]  Buf_RdData;
  logic        Crc_Init;
  logic        Crc_Update;
  logic [7:0]  Crc_Byte;
  logic [15:0] Crc_Value;
  logic        Ser_Req;
  logic        Ser_Load;
  logic [7:0]  Ser_Byte;
  logic        Ser_ZeroIns;
  logic        Tx_ValidFrame;
  logic        Tx_Done;
  logic        Tx_AbortedTrans;

  logic [7:0] mem [0:127];
  int n_checks = 0;
  int n_pass   = 0;

  assign Buf_RdData = mem[Buf_RdAddr];

  always #5 Clk = ~Clk;

  hdlc_tx_frame_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame), .Tx_FrameSize(Tx_FrameSize),
    .Buf_RdAddr(Buf_RdAddr), .Buf_RdData(Buf_RdData),
    .Crc_Init(Crc_Init), .Crc_Update(Crc_Update), .Crc_Byte(Crc_Byte), .Crc_Value(Crc_Value),
    .Ser_Req(Ser_Req), .Ser_Load(Ser_Load), .Ser_Byte(Ser_Byte), .Ser_ZeroIns(Ser_ZeroIns),
    .Tx_ValidFrame(Tx_ValidFrame), .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // one request spaced 8 cycles apart, load checked the cycle after the request
  task automatic do_req(input logic [7:0] exp_byte, input logic exp_zi,
                        input logic exp_upd, input string tag);
    @(negedge Clk) Ser_Req = 1'b1;
    @(negedge Clk) Ser_Req = 1'b0;
    chk({tag, ".load"}, Ser_Load, 1);
    chk({tag, ".byte"}, Ser_Byte, exp_byte);
    chk({tag, ".zi"}, Ser_ZeroIns, exp_zi);
    chk({tag, ".crc_upd"}, Crc_Update, exp_upd);
    if (exp_upd) chk({tag, ".crc_byte"}, Crc_Byte, exp_byte);
    @(negedge Clk);
    chk({tag, ".one_load"}, Ser_Load, 0);
    chk({tag, ".hold"}, Ser_Byte, exp_byte);
    repeat (5) @(negedge Clk);
  endtask

  task automatic pulse_en(input logic [7:0] size, input logic ab);
    @(negedge Clk);
    Tx_FrameSize  = size;
    Tx_Enable     = 1'b1;
    Tx_AbortFrame = ab;
    @(negedge Clk);
    Tx_Enable     = 1'b0;
    Tx_AbortFrame = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".addr"}, Buf_RdAddr, 0);
    chk({tag, ".ser_byte"}, Ser_Byte, 8'hFF);
    chk({tag, ".ser_load"}, Ser_Load, 0);
    chk({tag, ".zi"}, Ser_ZeroIns, 0);
    chk({tag, ".crc_init"}, Crc_Init, 0);
    chk({tag, ".crc_upd"}, Crc_Update, 0);
    chk({tag, ".crc_byte"}, Crc_Byte, 0);
    chk({tag, ".valid"}, Tx_ValidFrame, 0);
    chk({tag, ".done"}, Tx_Done, 1);
    chk({tag, ".aborted"}, Tx_AbortedTrans, 0);
  endtask

  initial begin
    Rst = 1'b0; Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Tx_FrameSize = 8'd0;
    Ser_Req = 1'b0; Crc_Value = 16'h0000;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    repeat (3) @(negedge Clk);
    chk_reset_vals("rst");
    Rst = 1'b1;

    // idle bytes
    for (int i = 0; i < 3; i++) begin
      do_req(8'hFF, 1'b0, 1'b0, "idle");
      chk("idle.done", Tx_Done, 1);
      chk("idle.valid", Tx_ValidFrame, 0);
      chk("idle.aborted", Tx_AbortedTrans, 0);
    end

    // basic 3-byte frame
    mem[0] = 8'hA5; mem[1] = 8'hFF; mem[2] = 8'h01;
    Crc_Value = 16'h1234;
    pulse_en(8'd3, 1'b0);
    chk("f3.crc_init", Crc_Init, 1);
    chk("f3.valid", Tx_ValidFrame, 1);
    chk("f3.done", Tx_Done, 0);
    chk("f3.addr", Buf_RdAddr, 0);
    @(negedge Clk);
    chk("f3.init_pulse", Crc_Init, 0);
    do_req(8'h7E, 1'b0, 1'b0, "f3.flag");
    do_req(8'hA5, 1'b1, 1'b1, "f3.d0");
    chk("f3.d0_done", Tx_Done, 0);
    do_req(8'hFF, 1'b1, 1'b1, "f3.d1");
    chk("f3.d1_done", Tx_Done, 0);
    do_req(8'h01, 1'b1, 1'b1, "f3.d2");
    chk("f3.d2_done", Tx_Done, 1);
    do_req(8'h34, 1'b1, 1'b0, "f3.fcs_lo");
    do_req(8'h12, 1'b1, 1'b0, "f3.fcs_hi");
    chk("f3.valid_pre_end", Tx_ValidFrame, 1);
    do_req(8'h7E, 1'b0, 1'b0, "f3.end");
    chk("f3.valid_end", Tx_ValidFrame, 0);
    do_req(8'hFF, 1'b0, 1'b0, "f3.post");

    // abort after second data byte
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h55;
    pulse_en(8'd5, 1'b0);
    chk("ab.crc_init", Crc_Init, 1);
    chk("ab.aborted_clr", Tx_AbortedTrans, 0);
    do_req(8'h7E, 1'b0, 1'b0, "ab.flag");
    do_req(8'h11, 1'b1, 1'b1, "ab.d0");
    do_req(8'h22, 1'b1, 1'b1, "ab.d1");
    @(negedge Clk) Tx_AbortFrame = 1'b1;
    @(negedge Clk) Tx_AbortFrame = 1'b0;
    chk("ab.aborted", Tx_AbortedTrans, 1);
    chk("ab.done", Tx_Done, 1);
    chk("ab.valid_hold", Tx_ValidFrame, 1);
    chk("ab.no_load", Ser_Load, 0);
    do_req(8'hFE, 1'b0, 1'b0, "ab.pattern");
    chk("ab.valid", Tx_ValidFrame, 0);
    do_req(8'hFF, 1'b0, 1'b0, "ab.idle");
    chk("ab.aborted_sticky", Tx_AbortedTrans, 1);

    // abort coinciding with a data request
    mem[0] = 8'hC1; mem[1] = 8'hC2; mem[2] = 8'hC3; mem[3] = 8'hC4;
    pulse_en(8'd4, 1'b0);
    do_req(8'h7E, 1'b0, 1'b0, "sc.flag");
    do_req(8'hC1, 1'b1, 1'b1, "sc.d0");
    chk("sc.addr_pre", Buf_RdAddr, 1);
    @(negedge Clk) begin Ser_Req = 1'b1; Tx_AbortFrame = 1'b1; end
    @(negedge Clk) begin Ser_Req = 1'b0; Tx_AbortFrame = 1'b0; end
    chk("sc.load", Ser_Load, 1);
    chk("sc.byte", Ser_Byte, 8'hFE);
    chk("sc.zi", Ser_ZeroIns, 0);
    chk("sc.crc_upd", Crc_Update, 0);
    chk("sc.addr", Buf_RdAddr, 1);
    chk("sc.aborted", Tx_AbortedTrans, 1);
    chk("sc.done", Tx_Done, 1);
    chk("sc.valid", Tx_ValidFrame, 0);
    @(negedge Clk);
    chk("sc.one_load", Ser_Load, 0);
    repeat (5) @(negedge Clk);
    do_req(8'hFF, 1'b0, 1'b0, "sc.idle");

    // rejected enables
    pulse_en(8'd0, 1'b0);
    chk("ign0.crc_init", Crc_Init, 0);
    chk("ign0.valid", Tx_ValidFrame, 0);
    chk("ign0.done", Tx_Done, 1);
    chk("ign0.addr", Buf_RdAddr, 1);
    pulse_en(8'd127, 1'b0);
    chk("ign127.crc_init", Crc_Init, 0);
    chk("ign127.valid", Tx_ValidFrame, 0);
    chk("ign127.aborted", Tx_AbortedTrans, 1);
    do_req(8'hFF, 1'b0, 1'b0, "ign.idle");

    // enable with abort in idle, then a busy enable that must be ignored
    mem[0] = 8'h5A; mem[1] = 8'hC3;
    Crc_Value = 16'hBEEF;
    pulse_en(8'd2, 1'b1);
    chk("ea.crc_init", Crc_Init, 1);
    chk("ea.valid", Tx_ValidFrame, 1);
    chk("ea.aborted", Tx_AbortedTrans, 0);
    pulse_en(8'd4, 1'b0);
    chk("busy.crc_init", Crc_Init, 0);
    chk("busy.addr", Buf_RdAddr, 0);
    do_req(8'h7E, 1'b0, 1'b0, "ea.flag");
    do_req(8'h5A, 1'b1, 1'b1, "ea.d0");
    do_req(8'hC3, 1'b1, 1'b1, "ea.d1");
    chk("ea.done", Tx_Done, 1);
    do_req(8'hEF, 1'b1, 1'b0, "ea.fcs_lo");
    do_req(8'hBE, 1'b1, 1'b0, "ea.fcs_hi");
    do_req(8'h7E, 1'b0, 1'b0, "ea.end");
    chk("ea.aborted_end", Tx_AbortedTrans, 0);

    // maximum-length frame, reset during FCS
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h3C;
    Crc_Value = 16'h9A5B;
    pulse_en(8'd126, 1'b0);
    chk("max.crc_init", Crc_Init, 1);
    do_req(8'h7E, 1'b0, 1'b0, "max.flag");
    for (int k = 0; k < 126; k++) do_req(8'(k) ^ 8'h3C, 1'b1, 1'b1, "max.data");
    chk("max.addr_peak", Buf_RdAddr, 125);
    chk("max.done", Tx_Done, 1);
    do_req(8'h5B, 1'b1, 1'b0, "max.fcs_lo");
    chk("max.addr_hold", Buf_RdAddr, 125);
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge Clk) Rst = 1'b1;
    do_req(8'hFF, 1'b0, 1'b0, "midrst.idle");
    chk("midrst.valid", Tx_ValidFrame, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_frame_ctrl.md
Name: hdlc_tx_frame_ctrl

Overview:
Frame-level sequencer for the HDLC transmit path. It sits between the Tx buffer/CRC unit and the bit serializer. On each byte request from the serializer it chooses what to send next: idle, flag, buffer data, FCS or abort pattern. It also drives Tx_ValidFrame, Tx_Done and Tx_AbortedTrans.

Parameters:
MAX_BYTES, 126, largest accepted Tx_FrameSize (payload bytes, excluding FCS).
IDLE_BYTE, 8'hFF, byte loaded when no frame is active.
FLAG_BYTE, 8'h7E, start/end flag.
ABORT_BYTE, 8'hFE, abort pattern; sent LSB first, so the 0 goes out first, then seven 1s.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous, active-low reset.
Tx_Enable  in  1  single-cycle frame start request.
Tx_AbortFrame  in  1  single-cycle abort request.
Tx_FrameSize  in  8  payload byte count in buffer.
Buf_RdAddr  out  7  buffer read address.
Buf_RdData  in  8  buffer data, combinational from Buf_RdAddr.
Crc_Init  out  1  CRC clear pulse.
Crc_Update  out  1  CRC accumulate pulse.
Crc_Byte  out  8  byte to accumulate.
Crc_Value  in  16  CRC result; valid 1 cycle after the last Crc_Update.
Ser_Req  in  1  serializer pulse: ready for next byte.
Ser_Load  out  1  byte-valid pulse to serializer.
Ser_Byte  out  8  byte to serialize.
Ser_ZeroIns  out  1  enable zero insertion for this byte.
Tx_ValidFrame  out  1  frame in progress.
Tx_Done  out  1  buffer fully consumed / controller free.
Tx_AbortedTrans  out  1  last frame was aborted (sticky).

Behaviour:
- Reset values:
  - State IDLE; Buf_RdAddr=0; Ser_Byte=IDLE_BYTE.
  - Ser_Load, Ser_ZeroIns, Crc_Init, Crc_Update, Tx_ValidFrame, Tx_AbortedTrans = 0; Crc_Byte=0.
  - Tx_Done=1.
- Load handshake:
  - Ser_Req at cycle t gives Ser_Load=1 at t+1, with Ser_Byte/Ser_ZeroIns registered and valid that cycle. Exactly one load per request.
  - Ser_Byte holds its value until the next load.
- States and the byte sent per request:
  - IDLE sends IDLE_BYTE, zero insertion off.
  - START sends FLAG_BYTE, off, then goes to DATA.
  - DATA sends Buf_RdData at Buf_RdAddr, zero insertion on. Crc_Update=1 and Crc_Byte=the same byte in the same cycle as Ser_Load. Buf_RdAddr increments. After the byte at index Tx_FrameSize-1, Tx_Done is set and the state goes to FCS_LO.
  - FCS_LO sends Crc_Value[7:0], on. Crc_Value[15:8] is latched in the same cycle. Goes to FCS_HI.
  - FCS_HI sends the latched high byte, on. Goes to END.
  - END sends FLAG_BYTE, off. Tx_ValidFrame clears in the load cycle. Goes to IDLE.
  - ABORT sends ABORT_BYTE, off. Tx_ValidFrame clears in the load cycle. Goes to IDLE.
- Frame start:
  - Tx_Enable is accepted only in IDLE with 1 <= Tx_FrameSize <= MAX_BYTES; otherwise it is ignored with no output change.
  - On accept, next cycle: Crc_Init=1, Buf_RdAddr=0, Tx_Done=0, Tx_AbortedTrans=0, Tx_ValidFrame=1, state START.
  - Tx_FrameSize is latched at accept.
  - An idle byte already being serialized completes; the flag goes out on the next request.
- Abort:
  - Tx_AbortFrame in START, DATA, FCS_LO, FCS_HI or END goes to ABORT next cycle, then Tx_AbortedTrans=1 and Tx_Done=1.
  - Abort in IDLE or ABORT is ignored.
  - Ser_Req and Tx_AbortFrame in the same cycle: the abort wins, and the load carries ABORT_BYTE.
- Tx_Enable and Tx_AbortFrame together in IDLE: the enable is accepted and the abort ignored.
- Buf_RdAddr never exceeds MAX_BYTES-1; 7-bit, no wrap within a frame.
- Reset asserted mid-frame: immediate return to reset values; no end flag or abort is emitted.

Test Plan:
- Reset, then Ser_Req pulsed every 8 cycles -> each load carries Ser_Byte=8'hFF with Ser_ZeroIns=0; Tx_Done=1, Tx_ValidFrame=0, Tx_AbortedTrans=0.
- Tx_FrameSize=3, buffer {8'hA5,8'hFF,8'h01}, Tx_Enable, Crc_Value=16'h1234 -> load sequence 7E,A5,FF,01,34,12,7E.
  - Crc_Update pulses with A5, FF, 01.
  - Tx_Done rises after the 01 load.
  - Tx_ValidFrame falls at the final 7E load.
- Tx_FrameSize=5, Tx_AbortFrame after the 2nd data load -> the next load is 8'hFE; Tx_AbortedTrans=1, Tx_Done=1, then 8'hFF loads resume.
- Ser_Req and Tx_AbortFrame in the same cycle during DATA -> that load is 8'hFE, not buffer data; the buffer address does not advance.
- Tx_Enable with Tx_FrameSize=0, then 127, then with 4 while busy -> all ignored; Crc_Init is not pulsed.
- Tx_FrameSize=126 -> 126 data loads, Buf_RdAddr peaks at 125, FCS bytes follow; reset asserted mid-FCS -> outputs return to reset values asynchronously.
